instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the RV32 core, directly upstream of decode and wrapped around the PC Register.
//  Reads the current PC from the PC Register and issues single-outstanding word reads to instruction memory.
//  Returned words are buffered, each with its PC, in a small FIFO and presented to decode over valid/ready.
//  Computes the next PC (sequential +4 or redirect) and drives the PC Register's write port.
// PARAMETERS
//  ADDR_WIDTH  32            instruction address / PC width
//  DATA_WIDTH  32            instruction word width
//  DEPTH       2             instruction buffer entries (power of 2, >=2)
//  NOP         32'h00000013  value on o_Inst when o_InstValid=0 (addi x0,x0,0)
// PORTS
//  i_Clock         in   1           clock, all state on posedge
//  i_Reset         in   1           asynchronous, active-high reset
//  i_Pc            in   ADDR_WIDTH  current PC, from the PC Register o_RdData
//  o_PcWrEnable    out  1           PC Register write enable
//  o_PcNext        out  ADDR_WIDTH  PC Register write data
//  o_MemReq        out  1           memory read request
//  o_MemAddr       out  ADDR_WIDTH  request address, bits[1:0] forced to 0
//  i_MemReady      in   1           request accepted when o_MemReq & i_MemReady
//  i_MemValid      in   1           read data valid; >=1 cycle after acceptance
//  i_MemData       in   DATA_WIDTH  read data
//  i_Redirect      in   1           one-cycle pulse: branch/jump/trap, restart fetch
//  i_RedirectAddr  in   ADDR_WIDTH  redirect target; bits[1:0] forced to 0
//  o_InstValid     out  1           buffer head valid
//  o_Inst          out  DATA_WIDTH  head instruction; NOP when o_InstValid=0
//  o_InstPc        out  ADDR_WIDTH  PC of head instruction; 0 when invalid
//  i_InstReady     in   1           decode accepts head when o_InstValid & i_InstReady
// BEHAVIOUR
//  Reset (async): state=S_REQ, FIFO count=0; o_MemReq=0, o_PcWrEnable=0, o_InstValid=0, o_Inst=NOP, o_InstPc=0.
//  While i_Reset=1, all outputs hold reset values; the PC Register itself supplies the reset vector on i_Pc.
//  FSM states S_REQ, S_WAIT, S_DROP (encoding in package).
//   S_REQ: o_MemReq=1 iff (count<DEPTH) & !i_Redirect; o_MemAddr=i_Pc.
//          On accept: o_PcWrEnable=1, o_PcNext=i_Pc+4 (wraps modulo 2^ADDR_WIDTH), latch i_Pc as ReqPc, go to S_WAIT.
//   S_WAIT: o_MemReq=0. On i_MemValid: push {i_MemData, ReqPc}, go to S_REQ.
//           A new request may issue no earlier than the cycle after the response.
//   S_DROP: o_MemReq=0. On i_MemValid: discard data, go to S_REQ.
//  Redirect (highest priority, any state): o_PcWrEnable=1, o_PcNext=i_RedirectAddr&~3; FIFO flushed that cycle.
//   Any pop in that cycle is suppressed and o_InstValid reads 0.
//   State next: S_WAIT -> S_DROP (a same-cycle i_MemValid counts as the drop completing -> S_REQ);
//   S_DROP stays in S_DROP unless i_MemValid; S_REQ stays in S_REQ.
//   No request issues in the redirect cycle; first post-redirect request is next cycle at the new PC.
//  Latency: request accepted at cycle N, response at N+k -> o_InstValid=1 at N+k+1 (registered FIFO).
//  Throughput with 1-cycle memory: one instruction every 2 cycles (single outstanding).
//  FIFO: simultaneous push and pop allowed at any count, count unchanged. Push never occurs when full,
//   because a request requires count<DEPTH at issue and DEPTH>=2 covers pop-less stalls.
//  o_PcWrEnable is 0 in every cycle without accept or redirect; the PC Register then holds.
//  Decode stall (i_InstReady=0): head is stable, o_Inst/o_InstPc unchanged until popped or flushed.
// STRUCTURE
//  Package fetch_pkg: state enum {S_REQ,S_WAIT,S_DROP}, NOP constant, PC_STEP=4, fetch entry struct {inst,pc}.
//  Sub-module fetch_fifo: sync FIFO, DEPTH entries of fetch entry, push/pop/flush, count, registered head.
//  Top level holds the FSM, ReqPc register and next-PC mux. The PC Register is instantiated by the parent, not here.
// TESTING
//  Reset PC 0x0, mem ready=1, 1-cycle latency, i_InstReady=1 -> PCs 0x0,0x4,0x8 emitted every 2 cycles; PcNext 0x4,0x8,0xC.
//  i_InstReady=0 -> after 2 fetches o_MemReq=0 with count=2; releasing ready drains 0x0 then 0x4, then fetch resumes at 0x8.
//  i_Redirect to 0x103 while in S_WAIT -> o_PcNext=0x100; stale response dropped; next o_InstPc=0x100; buffer emptied.
//  Redirect in the same cycle as i_MemValid in S_WAIT -> data discarded, state S_REQ, next request at redirect target.
//  i_Pc=0xFFFFFFFC accepted -> o_PcNext=0x00000000 (wrap).
//  Assert i_Reset mid-S_WAIT -> outputs go to reset values immediately (async); no push after reset release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port plus the decode-facing valid/ready port of the fetch stage.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                  o_MemReq;
    logic [ADDR_WIDTH-1:0] o_MemAddr;
    logic                  i_MemReady;
    logic                  i_MemValid;
    logic [DATA_WIDTH-1:0] i_MemData;
    logic                  o_InstValid;
    logic [DATA_WIDTH-1:0] o_Inst;
    logic [ADDR_WIDTH-1:0] o_InstPc;
    logic                  i_InstReady;

    modport master (
        output o_MemReq, o_MemAddr, o_InstValid, o_Inst, o_InstPc,
        input  i_MemReady, i_MemValid, i_MemData, i_InstReady
    );

    modport slave (
        input  o_MemReq, o_MemAddr, o_InstValid, o_Inst, o_InstPc,
        output i_MemReady, i_MemValid, i_MemData, i_InstReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: push/pop/flush, occupancy count, head read from registers.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         entry_t = fetch_pkg::fetch_entry_t,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Push,
    input  entry_t           i_PushData,
    input  logic             i_Pop,
    input  logic             i_Flush,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Valid,
    output entry_t           o_Head
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_en, pop_en;

    assign push_en = i_Push & (count_q != FULL) & ~i_Flush;
    assign pop_en  = i_Pop & (count_q != '0) & ~i_Flush;

    always_ff @(posedge i_Clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= i_PushData;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_Flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_Count = count_q;
    assign o_Valid = (count_q != '0);
    assign o_Head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// RV32 fetch stage: single-outstanding instruction reads, buffered to decode, drives PC Register writes.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ADDR_WIDTH-1:0] i_Pc,
    output logic                  o_PcWrEnable,
    output logic [ADDR_WIDTH-1:0] o_PcNext,
    input  logic                  i_Redirect,
    input  logic [ADDR_WIDTH-1:0] i_RedirectAddr,
    instruction_fetch_if.master   bus
);

    localparam int unsigned           CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]      FULL       = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  redirect, accept, push, pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_valid;
    entry_t                fifo_head, push_data;

    // Outputs must sit at reset values while reset is held, so gate the pulse here.
    assign redirect  = i_Redirect & ~i_Reset;
    assign push_data = '{inst: bus.i_MemData, pc: req_pc_q};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= S_REQ;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) req_pc_q <= i_Pc;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_MemValid) state_d = S_REQ;
                else if (redirect)  state_d = S_DROP;
            end
            S_DROP: begin
                if (bus.i_MemValid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        bus.o_MemReq = ~i_Reset & (state_q == S_REQ) & (fifo_count < FULL) & ~redirect;
        bus.o_MemAddr = i_Pc & ALIGN_MASK;
        accept       = bus.o_MemReq & bus.i_MemReady;
        o_PcWrEnable = accept | redirect;
        o_PcNext     = redirect ? (i_RedirectAddr & ALIGN_MASK) : (i_Pc + ADDR_WIDTH'(PC_STEP));

        // A response landing with a redirect is stale, never buffered.
        push = (state_q == S_WAIT) & bus.i_MemValid & ~redirect & ~i_Reset;

        bus.o_InstValid = fifo_valid & ~redirect & ~i_Reset;
        pop             = bus.o_InstValid & bus.i_InstReady;
        bus.o_Inst      = bus.o_InstValid ? fifo_head.inst : DATA_WIDTH'(NOP);
        bus.o_InstPc    = bus.o_InstValid ? fifo_head.pc : '0;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (push),
        .i_PushData (push_data),
        .i_Pop      (pop),
        .i_Flush    (redirect),
        .o_Count    (fifo_count),
        .o_Valid    (fifo_valid),
        .o_Head     (fifo_head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: queue-based reference model, bench-side PC Register and memory.
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q, pc_next, redir_addr;
    logic        pc_we, redir;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Pc           (pc_q),
        .o_PcWrEnable   (pc_we),
        .o_PcNext       (pc_next),
        .i_Redirect     (redir),
        .i_RedirectAddr (redir_addr),
        .bus            (bus)
    );

    // PC Register, reset vector 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pc_q <= 32'h0;
        else if (pc_we) pc_q <= pc_next;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          ready_pct = 100, inst_ready_pct = 100, lat_min = 1, lat_max = 1;
    bit          rst_knob = 1'b1, redir_knob = 1'b0;
    logic [31:0] redir_knob_addr = 32'h0;

    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t        m_q[$];
    bit          m_busy, m_stale;
    logic [31:0] m_pc, m_reqpc;

    logic [31:0] emitted[$];
    int          emit_cyc[$];
    logic [31:0] nexts[$];
    logic        snap_req, snap_we;
    logic [31:0] snap_addr, snap_next;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] emit_at(input int i);
        return (i < emitted.size()) ? emitted[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] next_at(input int i);
        return (i < nexts.size()) ? nexts[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_pc    = 32'h0;
        m_reqpc = 32'h0;
    endtask

    task automatic clear_logs();
        emitted.delete();
        emit_cyc.delete();
        nexts.delete();
    endtask

    task automatic cycle();
        logic        exp_req, exp_we, exp_valid;
        logic [31:0] exp_inst, exp_ipc, exp_next;
        @(posedge clk);
        #1;
        cyc++;
        rst                = rst_knob;
        redir              = redir_knob;
        redir_addr         = redir_knob ? redir_knob_addr : $urandom;
        bus.i_MemReady     = ($urandom_range(0, 99) < ready_pct);
        bus.i_InstReady    = ($urandom_range(0, 99) < inst_ready_pct);
        bus.i_MemValid     = 1'b0;
        bus.i_MemData      = $urandom;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.i_MemValid = 1'b1;
                bus.i_MemData  = memf(pend_addr);
            end
        end
        @(negedge clk);
        exp_req   = !rst && !m_busy && (m_q.size() < DEPTH) && !redir;
        exp_we    = !rst && ((exp_req && bus.i_MemReady) || redir);
        exp_next  = redir ? (redir_addr & ~32'h3) : (m_pc + 32'd4);
        exp_valid = !rst && (m_q.size() > 0) && !redir;
        exp_inst  = exp_valid ? m_q[0].inst : NOP;
        exp_ipc   = exp_valid ? m_q[0].pc : 32'h0;

        chk("mem_req", 32'(bus.o_MemReq), 32'(exp_req));
        if (exp_req) chk("mem_addr", bus.o_MemAddr, m_pc & ~32'h3);
        chk("pc_we", 32'(pc_we), 32'(exp_we));
        if (exp_we) chk("pc_next", pc_next, exp_next);
        chk("inst_valid", 32'(bus.o_InstValid), 32'(exp_valid));
        chk("inst", bus.o_Inst, exp_inst);
        chk("inst_pc", bus.o_InstPc, exp_ipc);

        snap_req  = bus.o_MemReq;
        snap_addr = bus.o_MemAddr;
        snap_we   = pc_we;
        snap_next = pc_next;
        if (bus.o_InstValid && bus.i_InstReady) begin
            emitted.push_back(bus.o_InstPc);
            emit_cyc.push_back(cyc);
        end
        if (pc_we) nexts.push_back(pc_next);

        if (bus.o_MemReq && bus.i_MemReady) begin
            pend_addr = bus.o_MemAddr;
            pend_cnt  = $urandom_range(lat_min, lat_max);
        end

        if (rst) begin
            model_reset();
        end else if (redir) begin
            m_q.delete();
            if (m_busy) begin
                if (bus.i_MemValid) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end
            m_pc = redir_addr & ~32'h3;
        end else begin
            if (exp_valid && bus.i_InstReady) void'(m_q.pop_front());
            if (m_busy && bus.i_MemValid) begin
                if (!m_stale) m_q.push_back('{inst: bus.i_MemData, pc: m_reqpc});
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req && bus.i_MemReady) begin
                m_busy  = 1'b1;
                m_reqpc = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_knob = 1'b1;
        redir_knob = 1'b0;
        repeat (n) cycle();
        rst_knob = 1'b0;
    endtask

    task automatic run_until_busy();
        for (int i = 0; i < 10 && !m_busy; i++) cycle();
        chk("reach_wait", 32'(m_busy), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_MemReady  = 1'b0;
        bus.i_MemValid  = 1'b0;
        bus.i_MemData   = 32'h0;
        bus.i_InstReady = 1'b0;
        redir           = 1'b0;
        redir_addr      = 32'h0;
        model_reset();

        do_reset(3);
        chk("rst_mem_req", 32'(bus.o_MemReq), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_inst_valid", 32'(bus.o_InstValid), 32'd0);
        chk("rst_inst", bus.o_Inst, 32'h0000_0013);
        chk("rst_inst_pc", bus.o_InstPc, 32'h0);

        // Back-to-back fetch with 1-cycle memory
        clear_logs();
        repeat (8) cycle();
        chk("seq_pc0", emit_at(0), 32'h0);
        chk("seq_pc1", emit_at(1), 32'h4);
        chk("seq_pc2", emit_at(2), 32'h8);
        chk("seq_next0", next_at(0), 32'h4);
        chk("seq_next1", next_at(1), 32'h8);
        chk("seq_next2", next_at(2), 32'hC);
        chk("seq_spacing", 32'((emit_cyc.size() > 1) ? emit_cyc[1] - emit_cyc[0] : 0), 32'd2);

        // Decode stall fills the buffer, then drains in order
        do_reset(2);
        inst_ready_pct = 0;
        repeat (10) cycle();
        chk("stall_req", 32'(snap_req), 32'd0);
        chk("stall_valid", 32'(bus.o_InstValid), 32'd1);
        chk("stall_head_pc", bus.o_InstPc, 32'h0);
        chk("stall_head_inst", bus.o_Inst, memf(32'h0));
        inst_ready_pct = 100;
        clear_logs();
        repeat (8) cycle();
        chk("drain_pc0", emit_at(0), 32'h0);
        chk("drain_pc1", emit_at(1), 32'h4);
        chk("drain_pc2", emit_at(2), 32'h8);

        // Redirect while a request is outstanding
        do_reset(2);
        lat_min = 3; lat_max = 3;
        run_until_busy();
        clear_logs();
        redir_knob = 1'b1; redir_knob_addr = 32'h0000_0103;
        cycle();
        redir_knob = 1'b0;
        chk("redir_we", 32'(snap_we), 32'd1);
        chk("redir_next", snap_next, 32'h0000_0100);
        repeat (10) cycle();
        chk("redir_first_pc", emit_at(0), 32'h0000_0100);

        // Redirect coinciding with the response
        do_reset(2);
        lat_min = 2; lat_max = 2;
        run_until_busy();
        cycle();
        clear_logs();
        redir_knob = 1'b1; redir_knob_addr = 32'h0000_0200;
        cycle();
        redir_knob = 1'b0;
        cycle();
        chk("redir_mv_req", 32'(snap_req), 32'd1);
        chk("redir_mv_addr", snap_addr, 32'h0000_0200);
        repeat (6) cycle();
        chk("redir_mv_first_pc", emit_at(0), 32'h0000_0200);

        // PC wrap at the top of the address space
        do_reset(2);
        lat_min = 1; lat_max = 1;
        redir_knob = 1'b1; redir_knob_addr = 32'hFFFF_FFFC;
        cycle();
        redir_knob = 1'b0;
        cycle();
        chk("wrap_addr", snap_addr, 32'hFFFF_FFFC);
        chk("wrap_next", snap_next, 32'h0000_0000);

        // Asynchronous reset in the middle of an outstanding request
        do_reset(2);
        lat_min = 3; lat_max = 3;
        run_until_busy();
        @(posedge clk);
        #3;
        rst = 1'b1;
        rst_knob = 1'b1;
        #1;
        chk("async_mem_req", 32'(bus.o_MemReq), 32'd0);
        chk("async_pc_we", 32'(pc_we), 32'd0);
        chk("async_valid", 32'(bus.o_InstValid), 32'd0);
        chk("async_inst", bus.o_Inst, 32'h0000_0013);
        chk("async_inst_pc", bus.o_InstPc, 32'h0);
        model_reset();
        repeat (5) cycle();
        rst_knob = 1'b0;
        clear_logs();
        repeat (8) cycle();
        chk("post_rst_pc0", emit_at(0), 32'h0);

        // Randomized traffic against the model
        ready_pct = 70; inst_ready_pct = 70;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            redir_knob      = ($urandom_range(0, 29) == 0);
            redir_knob_addr = $urandom;
            cycle();
        end
        redir_knob = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
